// File: rtl/rnd_clk_mon.sv
// Random clock monitor: measures rise-to-rise period, high time, min/max period and edge count.
// Optional macro RND_CLK_MON_SYNC_EN inserts a 2-flop synchronizer in front of edge detection.
module rnd_clk_mon #(
  parameter int CW = 8,
  parameter int NW = 16
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_rnd_clk,
  input  logic          i_clr,
  output logic          o_valid,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_high,
  output logic [CW-1:0] o_min,
  output logic [CW-1:0] o_max,
  output logic [NW-1:0] o_edge_cnt,
  output logic          o_ovf
);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] EDGE_MAX  = {NW{1'b1}};
  localparam logic [NW-1:0] EDGE_ZERO = {NW{1'b0}};
  localparam logic [NW-1:0] EDGE_ONE  = {{(NW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, MEAS = 1'b1} state_t;

  function automatic logic [CW-1:0] sat_inc_f(input logic [CW-1:0] cnt);
    sat_inc_f = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  function automatic logic [CW-1:0] min_f(input logic [CW-1:0] a, input logic [CW-1:0] b);
    min_f = (a < b) ? a : b;
  endfunction

  function automatic logic [CW-1:0] max_f(input logic [CW-1:0] a, input logic [CW-1:0] b);
    max_f = (a > b) ? a : b;
  endfunction

  logic          samp_s;
  logic          rise_s;
  logic          fall_s;
  logic          rnd_d_r;
  state_t        state_r;
  logic [CW-1:0] per_cnt_r;
  logic [CW-1:0] hi_cnt_r;
  logic          valid_r;
  logic [CW-1:0] period_r;
  logic [CW-1:0] high_r;
  logic [CW-1:0] min_r;
  logic [CW-1:0] max_r;
  logic [NW-1:0] edge_cnt_r;
  logic          ovf_r;

`ifdef RND_CLK_MON_SYNC_EN
  logic [1:0] sync_r;

  // Two-flop synchronizer for a source from a foreign clock domain
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], i_rnd_clk};
    end
  end

  assign samp_s = sync_r[1];
`else
  assign samp_s = i_rnd_clk;
`endif

  // Previous sample for edge detection; keeps running through a clear
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rnd_d_r <= 1'b0;
    end else begin
      rnd_d_r <= samp_s;
    end
  end

  assign rise_s = samp_s & ~rnd_d_r;
  assign fall_s = ~samp_s & rnd_d_r;

  // Measurement FSM with counters and statistics registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r    <= IDLE;
      per_cnt_r  <= CNT_ZERO;
      hi_cnt_r   <= CNT_ZERO;
      valid_r    <= 1'b0;
      period_r   <= CNT_ZERO;
      high_r     <= CNT_ZERO;
      min_r      <= CNT_MAX;
      max_r      <= CNT_ZERO;
      edge_cnt_r <= EDGE_ZERO;
      ovf_r      <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (i_clr) begin
        state_r    <= IDLE;
        per_cnt_r  <= CNT_ZERO;
        hi_cnt_r   <= CNT_ZERO;
        period_r   <= CNT_ZERO;
        high_r     <= CNT_ZERO;
        min_r      <= CNT_MAX;
        max_r      <= CNT_ZERO;
        edge_cnt_r <= EDGE_ZERO;
        ovf_r      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            // First rise only arms: there is no earlier edge to measure from
            if (rise_s) begin
              state_r    <= MEAS;
              per_cnt_r  <= CNT_ONE;
              hi_cnt_r   <= CNT_ONE;
              edge_cnt_r <= (edge_cnt_r == EDGE_MAX) ? edge_cnt_r : edge_cnt_r + EDGE_ONE;
            end
          end
          MEAS: begin
            if (rise_s) begin
              period_r   <= per_cnt_r;
              min_r      <= min_f(min_r, per_cnt_r);
              max_r      <= max_f(max_r, per_cnt_r);
              valid_r    <= 1'b1;
              edge_cnt_r <= (edge_cnt_r == EDGE_MAX) ? edge_cnt_r : edge_cnt_r + EDGE_ONE;
              per_cnt_r  <= CNT_ONE;
              hi_cnt_r   <= CNT_ONE;
            end else begin
              per_cnt_r <= sat_inc_f(per_cnt_r);
              if (per_cnt_r == CNT_MAX) begin
                ovf_r <= 1'b1;
              end
              if (fall_s) begin
                high_r <= hi_cnt_r;
              end else if (samp_s) begin
                hi_cnt_r <= sat_inc_f(hi_cnt_r);
                if (hi_cnt_r == CNT_MAX) begin
                  ovf_r <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_valid    = valid_r;
  assign o_period   = period_r;
  assign o_high     = high_r;
  assign o_min      = min_r;
  assign o_max      = max_r;
  assign o_edge_cnt = edge_cnt_r;
  assign o_ovf      = ovf_r;

endmodule

// File: doc/rnd_clk_mon.md
Name: rnd_clk_mon

Overview:
Downstream monitor for the random clock output of the random clock generator. Samples the random clock as data in the system clock domain and detects its edges. Measures each period and high time in system clock cycles, and keeps running min/max period and an edge count. Used by benches and on-chip debug to qualify random clock statistics without a scope.

Parameters:
CW, 8, width of period/high-time counters and of the min/max registers
NW, 16, width of the rising-edge counter

Ports:
i_clk  input  1  system clock
i_rstn  input  1  asynchronous active-low reset
i_rnd_clk  input  1  random clock, sampled as data on i_clk
i_clr  input  1  synchronous clear of state and statistics
o_valid  output  1  one-cycle pulse: o_period/o_min/o_max just updated
o_period  output  CW  last measured rise-to-rise period, in i_clk cycles
o_high  output  CW  last measured rise-to-fall high time, in i_clk cycles
o_min  output  CW  minimum period since reset/clear
o_max  output  CW  maximum period since reset/clear
o_edge_cnt  output  NW  rising edges seen since reset/clear
o_ovf  output  1  sticky: a period or high-time counter saturated

Behaviour:
- Clocking/reset: one clock, i_clk. Reset is asynchronous and active-low on i_rstn. All state is on posedge i_clk / negedge i_rstn.
- Reset values: o_valid=0, o_period=0, o_high=0, o_min={CW{1}}, o_max=0, o_edge_cnt=0, o_ovf=0, state=IDLE, sample register rnd_d=0.
- Edge detect: rnd_d <= s (s = sampled input, see Optional Feature). rise = s & ~rnd_d; fall = ~s & rnd_d.
- FSM: IDLE, MEAS.
  - IDLE: on rise -> MEAS, per_cnt<=1, hi_cnt<=1, o_edge_cnt++. No o_valid (no prior edge to measure from).
  - MEAS, rise: o_period<=per_cnt; o_min<=min(o_min,per_cnt); o_max<=max(o_max,per_cnt); o_valid<=1 next cycle; o_edge_cnt++; per_cnt<=1; hi_cnt<=1.
  - MEAS, fall: o_high<=hi_cnt; hi_cnt holds.
  - MEAS, no edge: per_cnt++. hi_cnt++ while s=1.
- Latency: o_valid is high exactly one cycle, in the cycle after the posedge where rise is detected. Outputs are registered at that same posedge.
- Period definition: number of i_clk posedges between consecutive detected rises. Minimum legal period is 2.
- Saturation: per_cnt/hi_cnt stop at 2^CW-1 and set o_ovf=1. A saturated value is reported as-is. o_edge_cnt stops at 2^NW-1, without setting o_ovf.
- i_clr=1: state->IDLE. All outputs return to reset values except rnd_d, which keeps sampling. Clear wins over a simultaneous rise: that rise is discarded, and the next rise re-arms.
- Input held constant in MEAS: per_cnt saturates, o_ovf=1, no o_valid.
- Asynchronous reset mid-measurement: immediate return to reset values. The first rise after release only arms the FSM.

Optional Feature:
Macro RND_CLK_MON_SYNC_EN.
- Defined: i_rnd_clk passes through a 2-flop synchronizer (reset 0) before s. Edge detection and o_valid are delayed by 2 i_clk cycles; measured values are unchanged. Use when i_rnd_clk comes from another domain.
- Undefined: s = i_rnd_clk directly (source is synchronous to i_clk, as with the random clock generator).

Test Plan:
- Reset: hold i_rstn=0 for 4 cycles -> all outputs at reset values, o_min=8'hFF.
- Fixed waveform, 3 high/3 low, 5 periods -> o_valid pulses 4 times, o_period=6, o_high=3, o_min=o_max=6, o_edge_cnt=5.
- Alternating periods 2 and 9 (1-high pulses) -> o_min=2, o_max=9, o_high=1, o_ovf=0.
- Hold i_rnd_clk=1 for 300 cycles after arming (CW=8) -> o_ovf=1; next rise reports o_period=255.
- i_clr asserted in the same cycle as a rise -> edge count 0, state IDLE, no o_valid. Following rise arms; the one after gives a valid period.
- Chain with the random clock generator (SEED=1), 1500 cycles -> every o_period equals the bench-computed rise-to-rise gap, o_period>=2, o_edge_cnt equals the bench count. Repeat with RND_CLK_MON_SYNC_EN defined: same values, o_valid 2 cycles later.
